register_nbit_universal: RTL and testbench
==========================================

// Module: register_nbit_universal
// PURPOSE
//   Parametrised successor to the 8-bit load register: a WIDTH-bit universal register.
//   Supports hold, parallel load, logical/arithmetic shift, rotate and clear.
//   Adds a built-in serialiser that shifts a loaded word out one bit per clock,
//   with busy/done handshake. Used as a general datapath register and as a simple
//   parallel-to-serial stage feeding serial links.
// PARAMETERS
//   WIDTH      8  register width in bits (>= 2)
//   RESET_VAL  0  value loaded into data_out on reset (WIDTH bits)
//   MSB_FIRST  1  serialiser order: 1 = MSB first, 0 = LSB first
// PORTS
//   CLK       in   1      clock, all state updates on rising edge
//   RST       in   1      reset, synchronous, active-low
//   mode      in   3      register operation when idle (see BEHAVIOUR)
//   ser_in_l  in   1      bit shifted into bit 0 on shift-left
//   ser_in_r  in   1      bit shifted into bit WIDTH-1 on logical shift-right
//   data_in   in   WIDTH  parallel load / serialiser source word
//   start     in   1      begin serial transmission of data_in
//   data_out  out  WIDTH  register contents
//   ser_out   out  1      serial output bit
//   busy      out  1      serialiser active
//   done      out  1      one-cycle pulse, serialisation complete
// BEHAVIOUR
//   Reset (RST=0 at edge): data_out=RESET_VAL, busy=0, done=0, bit counter=0.
//     Reset overrides everything, including mid-serialisation (sequence aborted, no done).
//   States: IDLE, SHIFT. State is visible as busy (SHIFT => busy=1).
//   IDLE, start=1: data_out<=data_in, counter<=WIDTH-1, go SHIFT; mode ignored that cycle.
//   IDLE, start=0: mode applied at the edge:
//     000 hold     data_out unchanged
//     001 load     data_out<=data_in
//     010 shl      data_out<={data_out[W-2:0],ser_in_l}
//     011 shr      data_out<={ser_in_r,data_out[W-1:1]}
//     100 rotl     data_out<={data_out[W-2:0],data_out[W-1]}
//     101 rotr     data_out<={data_out[0],data_out[W-1:1]}
//     110 asr      data_out<={data_out[W-1],data_out[W-1:1]} (sign kept)
//     111 clear    data_out<=0
//   SHIFT: mode, start, ser_in_* ignored. Each edge shifts toward the output end,
//     zero fill (MSB_FIRST=1: shl with 0; else shr with 0), counter decrements.
//   ser_out (combinational): busy ? (MSB_FIRST ? data_out[W-1] : data_out[0]) : 0.
//     First bit is valid in the first busy cycle; exactly WIDTH bits, one per cycle.
//   Edge with counter==0 in SHIFT: go IDLE, busy<=0, done<=1 for one cycle.
//     data_out is all zeros after a complete sequence.
//   busy high for exactly WIDTH cycles; done high in the cycle after the last bit.
//   start during SHIFT is dropped (not queued); start in the done cycle is accepted.
//   done is 0 in every other cycle. Counter width $clog2(WIDTH), internal only.
// TESTING (WIDTH=8, RESET_VAL=0, MSB_FIRST=1 unless noted)
//   RST=0 one edge with data_out=8'hA5 -> data_out=8'h00, busy=0, done=0, ser_out=0.
//   load 8'h81; shl ser_in_l=1 -> 8'h03; rotr -> 8'h81; asr -> 8'hC0; clear -> 8'h00.
//   shr ser_in_r=1 from 8'h00 eight times -> 8'h80,8'hC0,...,8'hFF; hold keeps 8'hFF.
//   start with data_in=8'hB4 -> busy 8 cycles, ser_out 1,0,1,1,0,1,0,0; done pulse once.
//   MSB_FIRST=0, start data_in=8'hB4 -> ser_out 0,0,1,0,1,1,0,1; data_out=0 at end.
//   RST=0 at 4th busy cycle -> busy=0, done never pulses, data_out=8'h00; start on
//     busy cycle 3 with new data ignored; start in done cycle begins new sequence.

Source files
------------

// File: rtl/register_nbit_universal.sv
// WIDTH-bit universal register: hold/load/shift/rotate/clear, plus a built-in
// parallel-to-serial stage with busy/done handshake.
module register_nbit_universal #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_done;
  logic             w_done_next;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_data  <= RESET_VAL;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_data_next  = data_in;
          w_cnt_next   = CNT_LAST;
          w_state_next = S_SHIFT;
        end else begin
          case (mode)
            3'b000: w_data_next = r_data;
            3'b001: w_data_next = data_in;
            3'b010: w_data_next = {r_data[WIDTH-2:0], ser_in_l};
            3'b011: w_data_next = {ser_in_r, r_data[WIDTH-1:1]};
            3'b100: w_data_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            3'b101: w_data_next = {r_data[0], r_data[WIDTH-1:1]};
            3'b110: w_data_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            3'b111: w_data_next = '0;
          endcase
        end
      end
      S_SHIFT: begin
        // Zero fill means the register is empty once the last bit has left.
        if (MSB_FIRST)
          w_data_next = {r_data[WIDTH-2:0], 1'b0};
        else
          w_data_next = {1'b0, r_data[WIDTH-1:1]};
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
    endcase
  end

  assign data_out = r_data;
  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign ser_out  = busy ? (MSB_FIRST ? r_data[WIDTH-1] : r_data[0]) : 1'b0;

endmodule

// File: tb/tb_register_nbit_universal.sv
// Bench for register_nbit_universal: MSB-first and LSB-first instances share
// stimulus; a behavioural model is compared every cycle, plus literal checks.
module tb_register_nbit_universal;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic         ser_in_l = 1'b0;
  logic         ser_in_r = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         start = 1'b0;

  logic [W-1:0] dout_m, dout_l;
  logic         ser_m, ser_l, busy_m, busy_l, done_m, done_l;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  register_nbit_universal #(.WIDTH(W), .RESET_VAL(8'h00), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .mode(mode), .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
    .data_in(data_in), .start(start), .data_out(dout_m), .ser_out(ser_m),
    .busy(busy_m), .done(done_m)
  );

  register_nbit_universal #(.WIDTH(W), .RESET_VAL(8'h00), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST), .mode(mode), .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
    .data_in(data_in), .start(start), .data_out(dout_l), .ser_out(ser_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = MSB-first instance, 1 = LSB-first instance.
  // While transmitting, the register is simply the start word shifted by the
  // number of bits already sent.
  logic [W-1:0] m_data [2];
  logic [W-1:0] m_word [2];
  bit           m_act  [2];
  bit           m_done [2];
  int           m_k    [2];
  bit           m_valid = 1'b0;

  always @(posedge CLK) begin
    logic signed [W-1:0] t;
    for (int i = 0; i < 2; i++) begin
      if (!RST) begin
        m_data[i] = '0; m_act[i] = 1'b0; m_done[i] = 1'b0; m_k[i] = 0;
      end else if (m_act[i]) begin
        m_k[i]++;
        m_data[i] = (i == 0) ? (m_word[i] << m_k[i]) : (m_word[i] >> m_k[i]);
        if (m_k[i] == W) begin
          m_act[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          m_word[i] = data_in; m_data[i] = data_in; m_k[i] = 0; m_act[i] = 1'b1;
        end else begin
          case (mode)
            3'd0: ;
            3'd1: m_data[i] = data_in;
            3'd2: m_data[i] = (m_data[i] << 1) | W'(ser_in_l);
            3'd3: m_data[i] = (m_data[i] >> 1) | (W'(ser_in_r) << (W - 1));
            3'd4: m_data[i] = (m_data[i] << 1) | (m_data[i] >> (W - 1));
            3'd5: m_data[i] = (m_data[i] >> 1) | (m_data[i] << (W - 1));
            3'd6: begin t = m_data[i]; t = t >>> 1; m_data[i] = t; end
            default: m_data[i] = '0;
          endcase
        end
      end
    end
    if (!RST) m_valid = 1'b1;
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_data_m", 32'(dout_m), 32'(m_data[0]));
      chk("model_busy_m", 32'(busy_m), 32'(m_act[0]));
      chk("model_done_m", 32'(done_m), 32'(m_done[0]));
      chk("model_ser_m", 32'(ser_m), m_act[0] ? 32'(m_word[0][W-1-m_k[0]]) : 32'd0);
      chk("model_data_l", 32'(dout_l), 32'(m_data[1]));
      chk("model_busy_l", 32'(busy_l), 32'(m_act[1]));
      chk("model_done_l", 32'(done_l), 32'(m_done[1]));
      chk("model_ser_l", 32'(ser_l), m_act[1] ? 32'(m_word[1][m_k[1]]) : 32'd0);
    end
  end

  task automatic op(input logic [2:0] m, input logic sl, input logic sr,
                    input logic [W-1:0] d, input logic st);
    mode = m; ser_in_l = sl; ser_in_r = sr; data_in = d; start = st;
    @(negedge CLK);
  endtask

  logic [W-1:0] shr_exp [8];
  logic [W-1:0] got_m, got_l;

  initial begin
    shr_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;

    // Reset clears a loaded value.
    op(3'd1, 0, 0, 8'hA5, 0);
    chk("load_a5", 32'(dout_m), 32'h00A5);
    RST = 1'b0;
    op(3'd0, 0, 0, 8'h00, 0);
    chk("rst_data", 32'(dout_m), 32'h0000);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    chk("rst_ser", 32'(ser_m), 32'd0);
    RST = 1'b1;

    op(3'd1, 0, 0, 8'h81, 0); chk("load_81", 32'(dout_m), 32'h81);
    op(3'd2, 1, 0, 8'h00, 0); chk("shl", 32'(dout_m), 32'h03);
    op(3'd5, 0, 0, 8'h00, 0); chk("rotr", 32'(dout_m), 32'h81);
    op(3'd6, 0, 0, 8'h00, 0); chk("asr", 32'(dout_m), 32'hC0);
    op(3'd7, 0, 0, 8'h00, 0); chk("clear", 32'(dout_m), 32'h00);
    for (int k = 0; k < 8; k++) begin
      op(3'd3, 0, 1, 8'h00, 0);
      chk("shr_fill", 32'(dout_m), 32'(shr_exp[k]));
    end
    op(3'd0, 0, 0, 8'h00, 0); chk("hold", 32'(dout_m), 32'hFF);

    // Full transmission of B4 on both orders.
    op(3'd0, 0, 0, 8'hB4, 1);
    got_m = '0; got_l = '0;
    for (int k = 0; k < W; k++) begin
      chk("tx_busy", 32'(busy_m), 32'd1);
      chk("tx_no_done", 32'(done_m), 32'd0);
      got_m = {got_m[W-2:0], ser_m};
      got_l = {got_l[W-2:0], ser_l};
      op(3'd1, 0, 0, 8'h00, 0);
    end
    chk("tx_bits_msb", 32'(got_m), 32'hB4);
    chk("tx_bits_lsb", 32'(got_l), 32'h2D);
    chk("tx_done", 32'(done_m), 32'd1);
    chk("tx_idle", 32'(busy_m), 32'd0);
    chk("tx_zero_m", 32'(dout_m), 32'd0);
    chk("tx_zero_l", 32'(dout_l), 32'd0);
    op(3'd0, 0, 0, 8'h00, 0);
    chk("tx_done_once", 32'(done_m), 32'd0);

    // Start during busy ignored; reset mid-sequence aborts without done.
    op(3'd0, 0, 0, 8'h5A, 1);
    op(3'd0, 0, 0, 8'h00, 0);
    op(3'd0, 0, 0, 8'hFF, 1);
    op(3'd0, 0, 0, 8'hFF, 0);
    chk("busy_start_ignored", 32'(dout_m), 32'hD0);
    chk("busy_cycle4", 32'(busy_m), 32'd1);
    RST = 1'b0;
    op(3'd0, 0, 0, 8'h00, 0);
    RST = 1'b1;
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_data", 32'(dout_m), 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("abort_no_done", 32'(done_m), 32'd0);
      op(3'd0, 0, 0, 8'h00, 0);
    end

    // Start in the done cycle begins a new sequence.
    op(3'd0, 0, 0, 8'hC3, 1);
    for (int k = 0; k < W; k++) op(3'd0, 0, 0, 8'h00, 0);
    chk("done_before_restart", 32'(done_m), 32'd1);
    op(3'd0, 0, 0, 8'h3C, 1);
    chk("restart_busy", 32'(busy_m), 32'd1);
    chk("restart_data", 32'(dout_m), 32'h3C);
    for (int k = 0; k < W + 1; k++) op(3'd0, 0, 0, 8'h00, 0);

    // Randomized phase, checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      RST = ($urandom_range(0, 99) != 0);
      op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         8'($urandom), ($urandom_range(0, 9) == 0));
    end
    RST = 1'b1;
    op(3'd0, 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
